// File: rtl/cache_control_nway_if.sv
// Signal bundle between the N-way cache controller and its CPU, cache-datapath and memory neighbours.
interface cache_control_nway_if #(
  parameter int WAYS = 2
);
  localparam int WAY_W = $clog2(WAYS);

  logic             cpu_read;
  logic             cpu_write;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_way;
  logic [WAYS-1:0]  is_valid;
  logic [WAYS-1:0]  is_dirty;
  logic             ca_resp;

  logic             cpu_mem_valid;
  logic             lru_load;
  logic [WAY_W-1:0] lru_way;
  logic [WAY_W-1:0] wb_way;
  logic [WAYS-1:0]  load_data_lines;
  logic [WAYS-1:0]  load_data_bytes;
  logic [WAYS-1:0]  load_tag;
  logic [WAYS-1:0]  set_valid;
  logic [WAYS-1:0]  write_valid;
  logic [WAYS-1:0]  set_dirty;
  logic [WAYS-1:0]  write_dirty;
  logic             data_in_select;
  logic             mem_read;
  logic             mem_write;
  logic             busy;
  logic             error;

  modport master (
    input  cpu_read, cpu_write, hit, hit_way, victim_way, is_valid, is_dirty, ca_resp,
    output cpu_mem_valid, lru_load, lru_way, wb_way, load_data_lines, load_data_bytes,
           load_tag, set_valid, write_valid, set_dirty, write_dirty, data_in_select,
           mem_read, mem_write, busy, error
  );

  modport slave (
    output cpu_read, cpu_write, hit, hit_way, victim_way, is_valid, is_dirty, ca_resp,
    input  cpu_mem_valid, lru_load, lru_way, wb_way, load_data_lines, load_data_bytes,
           load_tag, set_valid, write_valid, set_dirty, write_dirty, data_in_select,
           mem_read, mem_write, busy, error
  );
endinterface

// File: rtl/cache_control_nway.sv
// Write-back/write-allocate N-way cache controller: hit completes 1 cycle after request; misses wait on
// the four-phase ca_resp handshake, CPU requests are held off (busy) until completion, watchdog gives a sticky error.
module cache_control_nway #(
  parameter int WAYS    = 2,
  parameter int TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  cache_control_nway_if.master bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, CHECK, WB_REQ, WB_DONE, FILL_REQ, FILL_DONE, ERROR
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             op;
  logic [WAY_W-1:0] victim;
  logic             retry;
  logic [CNT_W-1:0] cnt;

  logic             valid_hit;
  logic             victim_dirty;
  logic             waiting;
  logic             timeout;
  logic [WAYS-1:0]  hit_oh;
  logic [WAYS-1:0]  vic_oh;

  assign valid_hit    = bus.hit && bus.is_valid[bus.hit_way];
  assign victim_dirty = bus.is_valid[bus.victim_way] && bus.is_dirty[bus.victim_way];
  assign waiting      = state inside {WB_REQ, WB_DONE, FILL_REQ, FILL_DONE};
  assign timeout      = (TIMEOUT != 0) && waiting && (cnt == CNT_LAST);
  assign hit_oh       = WAYS'(1) << bus.hit_way;
  assign vic_oh       = WAYS'(1) << victim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      op     <= 1'b0;
      victim <= '0;
      retry  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || !waiting || TIMEOUT == 0)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      if (state == IDLE && (bus.cpu_read || bus.cpu_write)) begin
        op    <= bus.cpu_write;
        retry <= 1'b0;
      end
      if (state == CHECK && !valid_hit && !retry)
        victim <= bus.victim_way;
      if (state == FILL_DONE && !bus.ca_resp)
        retry <= 1'b1;
    end
  end

  // A handshake edge in the same cycle as the timeout wins, so requests never drop while ca_resp is high.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (bus.cpu_read || bus.cpu_write) state_nx = CHECK;
      CHECK: begin
        if (valid_hit)         state_nx = IDLE;
        else if (retry)        state_nx = ERROR;
        else if (victim_dirty) state_nx = WB_REQ;
        else                   state_nx = FILL_REQ;
      end
      WB_REQ:    if (bus.ca_resp)  state_nx = WB_DONE;   else if (timeout) state_nx = ERROR;
      WB_DONE:   if (!bus.ca_resp) state_nx = FILL_REQ;  else if (timeout) state_nx = ERROR;
      FILL_REQ:  if (bus.ca_resp)  state_nx = FILL_DONE; else if (timeout) state_nx = ERROR;
      FILL_DONE: if (!bus.ca_resp) state_nx = CHECK;     else if (timeout) state_nx = ERROR;
      ERROR:     if (!bus.cpu_read && !bus.cpu_write) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_mem_valid   = 1'b0;
    bus.lru_load        = 1'b0;
    bus.lru_way         = '0;
    bus.wb_way          = victim;
    bus.load_data_lines = '0;
    bus.load_data_bytes = '0;
    bus.load_tag        = '0;
    bus.set_valid       = '0;
    bus.write_valid     = '0;
    bus.set_dirty       = '0;
    bus.write_dirty     = '0;
    bus.data_in_select  = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.busy            = (state != IDLE);
    bus.error           = (state == ERROR);
    case (state)
      CHECK: begin
        if (valid_hit) begin
          bus.cpu_mem_valid = 1'b1;
          bus.lru_load      = 1'b1;
          bus.lru_way       = bus.hit_way;
          if (op) begin
            bus.load_data_bytes = hit_oh;
            bus.set_dirty       = hit_oh;
            bus.write_dirty     = hit_oh;
          end
        end
      end
      WB_REQ:   bus.mem_write = 1'b1;
      FILL_REQ: bus.mem_read  = 1'b1;
      FILL_DONE: begin
        // Fill lands on the falling edge of ca_resp; the line arrives clean.
        if (!bus.ca_resp) begin
          bus.load_data_lines = vic_oh;
          bus.load_tag        = vic_oh;
          bus.data_in_select  = 1'b1;
          bus.set_valid       = vic_oh;
          bus.write_valid     = vic_oh;
          bus.write_dirty     = vic_oh;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cache_control_nway.sv
// Directed-vector bench for cache_control_nway with WAYS=4, TIMEOUT=5.
module tb_cache_control_nway;
  typedef struct packed {
    logic       rd;
    logic       wr;
    logic       hit;
    logic [1:0] hw;
    logic [1:0] vw;
    logic [3:0] val;
    logic [3:0] dty;
    logic       resp;
  } in_t;

  typedef struct packed {
    logic       cmv;
    logic       lru;
    logic [1:0] lw;
    logic [1:0] wb;
    logic [3:0] ldl;
    logic [3:0] ldb;
    logic [3:0] ltag;
    logic [3:0] sv;
    logic [3:0] wv;
    logic [3:0] sd;
    logic [3:0] wd;
    logic       dsel;
    logic       mrd;
    logic       mwr;
    logic       busy;
    logic       err;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  vec_t tbl[$];

  cache_control_nway_if #(.WAYS(4)) bus();

  cache_control_nway #(.WAYS(4), .TIMEOUT(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(string n, in_t i, out_t e);
    vec_t v;
    v.name = n;
    v.i    = i;
    v.e    = e;
    tbl.push_back(v);
  endfunction

  task automatic drive(in_t i);
    bus.cpu_read   = i.rd;
    bus.cpu_write  = i.wr;
    bus.hit        = i.hit;
    bus.hit_way    = i.hw;
    bus.victim_way = i.vw;
    bus.is_valid   = i.val;
    bus.is_dirty   = i.dty;
    bus.ca_resp    = i.resp;
  endtask

  function automatic out_t get_out();
    out_t o;
    o.cmv  = bus.cpu_mem_valid;
    o.lru  = bus.lru_load;
    o.lw   = bus.lru_way;
    o.wb   = bus.wb_way;
    o.ldl  = bus.load_data_lines;
    o.ldb  = bus.load_data_bytes;
    o.ltag = bus.load_tag;
    o.sv   = bus.set_valid;
    o.wv   = bus.write_valid;
    o.sd   = bus.set_dirty;
    o.wd   = bus.write_dirty;
    o.dsel = bus.data_in_select;
    o.mrd  = bus.mem_read;
    o.mwr  = bus.mem_write;
    o.busy = bus.busy;
    o.err  = bus.error;
    return o;
  endfunction

  task automatic check(string n, out_t exp);
    out_t act;
    act = get_out();
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic check1(string n, logic act, logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", n, act, exp);
  endtask

  task automatic step(in_t i);
    @(negedge clk);
    drive(i);
    #1;
  endtask

  initial begin
    in_t  wm, rm, rg, fi, wd, ar;
    out_t z;
    n_pass  = 0;
    n_total = 0;
    z       = '0;

    // Cycle-by-cycle vectors: inputs in force for a cycle and the outputs expected in that cycle.
    add("rh_idle",  '{default:0, rd:1, hit:1, hw:2, val:4'b0100}, '{default:0});
    add("rh_check", '{default:0, rd:1, hit:1, hw:2, val:4'b0100}, '{default:0, cmv:1, lru:1, lw:2, busy:1});
    add("rh_done",  '{default:0}, '{default:0});

    wm = '{default:0, wr:1, vw:3};
    add("wm_idle",  wm, '{default:0});
    add("wm_check", wm, '{default:0, busy:1});
    add("wm_freq0", wm, '{default:0, busy:1, wb:3, mrd:1});
    add("wm_freq1", wm, '{default:0, busy:1, wb:3, mrd:1});
    add("wm_freq2", wm, '{default:0, busy:1, wb:3, mrd:1});
    wm.resp = 1'b1;
    add("wm_rise",  wm, '{default:0, busy:1, wb:3, mrd:1});
    add("wm_hold",  wm, '{default:0, busy:1, wb:3});
    wm.resp = 1'b0;
    add("wm_fill",  wm, '{default:0, busy:1, wb:3, ldl:4'b1000, ltag:4'b1000, dsel:1,
                          sv:4'b1000, wv:4'b1000, wd:4'b1000});
    add("wm_hit",   '{default:0, wr:1, hit:1, hw:3, vw:3, val:4'b1000},
                    '{default:0, cmv:1, lru:1, lw:3, wb:3, ldb:4'b1000, sd:4'b1000, wd:4'b1000, busy:1});
    add("wm_done",  '{default:0}, '{default:0, wb:3});

    rm = '{default:0, rd:1, vw:1, val:4'b0010, dty:4'b0010};
    add("rd_idle",  rm, '{default:0, wb:3});
    add("rd_check", rm, '{default:0, busy:1, wb:3});
    add("rd_wreq",  rm, '{default:0, busy:1, wb:1, mwr:1});
    rm.resp = 1'b1;
    add("rd_wrise", rm, '{default:0, busy:1, wb:1, mwr:1});
    add("rd_whold", rm, '{default:0, busy:1, wb:1});
    rm.resp = 1'b0;
    add("rd_wfall", rm, '{default:0, busy:1, wb:1});
    add("rd_freq",  rm, '{default:0, busy:1, wb:1, mrd:1});
    rm.resp = 1'b1;
    add("rd_frise", rm, '{default:0, busy:1, wb:1, mrd:1});
    rm.resp = 1'b0;
    add("rd_fill",  rm, '{default:0, busy:1, wb:1, ldl:4'b0010, ltag:4'b0010, dsel:1,
                          sv:4'b0010, wv:4'b0010, wd:4'b0010});
    add("rd_hit",   '{default:0, rd:1, hit:1, hw:1, vw:1, val:4'b0010},
                    '{default:0, cmv:1, lru:1, lw:1, wb:1, busy:1});
    add("rd_done",  '{default:0}, '{default:0, wb:1});

    // Retry guard: ca_resp already high when FILL_REQ is entered, then the line still misses.
    rg = '{default:0, rd:1, vw:2};
    add("rg_idle",  rg, '{default:0, wb:1});
    add("rg_check", rg, '{default:0, busy:1, wb:1});
    rg.resp = 1'b1;
    add("rg_freq",  rg, '{default:0, busy:1, wb:2, mrd:1});
    rg.resp = 1'b0;
    add("rg_fill",  rg, '{default:0, busy:1, wb:2, ldl:4'b0100, ltag:4'b0100, dsel:1,
                          sv:4'b0100, wv:4'b0100, wd:4'b0100});
    add("rg_miss",  rg, '{default:0, busy:1, wb:2});
    add("rg_err0",  rg, '{default:0, busy:1, wb:2, err:1});
    add("rg_err1",  rg, '{default:0, busy:1, wb:2, err:1});
    add("rg_errrel", '{default:0}, '{default:0, busy:1, wb:2, err:1});
    add("rg_idle2", '{default:0}, '{default:0, wb:2});

    add("pri_idle",  '{default:0, rd:1, wr:1, hit:1, hw:0, val:4'b0001}, '{default:0, wb:2});
    add("pri_check", '{default:0, rd:1, wr:1, hit:1, hw:0, val:4'b0001},
                     '{default:0, cmv:1, lru:1, lw:0, ldb:4'b0001, sd:4'b0001, wd:4'b0001, busy:1, wb:2});
    add("pri_done",  '{default:0}, '{default:0, wb:2});

    // Tag match on an invalid way is a miss; a dirty bit on an invalid victim needs no write-back.
    fi = '{default:0, rd:1, hit:1, hw:1, vw:1, val:4'b0001, dty:4'b0010};
    add("inv_idle",  fi, '{default:0, wb:2});
    add("inv_check", fi, '{default:0, busy:1, wb:2});
    add("inv_freq",  fi, '{default:0, busy:1, wb:1, mrd:1});
    fi.resp = 1'b1;
    add("inv_frise", fi, '{default:0, busy:1, wb:1, mrd:1});
    fi.resp = 1'b0;
    add("inv_fill",  fi, '{default:0, busy:1, wb:1, ldl:4'b0010, ltag:4'b0010, dsel:1,
                           sv:4'b0010, wv:4'b0010, wd:4'b0010});
    add("inv_hit",   '{default:0, rd:1, hit:1, hw:1, vw:1, val:4'b0011},
                     '{default:0, cmv:1, lru:1, lw:1, wb:1, busy:1});
    add("inv_done",  '{default:0}, '{default:0, wb:1});

    // Reset held with every input asserted: all outputs stay low.
    rst = 1'b0;
    drive('{default:0, rd:1, wr:1, hit:1, hw:3, vw:3, val:4'b1111, dty:4'b1111, resp:1});
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_hold", z);
    rst = 1'b1;
    drive('{default:0});

    foreach (tbl[k]) begin
      step(tbl[k].i);
      check(tbl[k].name, tbl[k].e);
    end

    // Watchdog: fill response never arrives.
    wd = '{default:0, rd:1, vw:0};
    step(wd);
    check1("wd_idle_busy", bus.busy, 1'b0);
    step(wd);
    check1("wd_check_busy", bus.busy, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(wd);
      check1("wd_wait_mrd", bus.mem_read, 1'b1);
      check1("wd_wait_err", bus.error, 1'b0);
    end
    step(wd);
    check1("wd_err", bus.error, 1'b1);
    check1("wd_err_mrd", bus.mem_read, 1'b0);
    step(wd);
    check1("wd_sticky", bus.error, 1'b1);
    step('{default:0});
    check1("wd_release_cycle", bus.error, 1'b1);
    step('{default:0});
    check1("wd_back_idle_busy", bus.busy, 1'b0);
    check1("wd_back_idle_err", bus.error, 1'b0);

    // Asynchronous reset in the middle of a write-back request.
    ar = '{default:0, rd:1, vw:3, val:4'b1000, dty:4'b1000};
    step(ar);
    step(ar);
    step(ar);
    check1("ar_wreq_mwr", bus.mem_write, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_reset_now", z);
    step(ar);
    check("ar_reset_held", z);
    @(negedge clk);
    rst = 1'b1;
    drive('{default:0, rd:1, hit:1, hw:0, val:4'b0001});
    #1;
    check("ar_new_idle", z);
    step('{default:0, rd:1, hit:1, hw:0, val:4'b0001});
    check("ar_new_hit", '{default:0, cmv:1, lru:1, lw:0, busy:1});
    step('{default:0});
    check("ar_new_done", z);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
